// File: rtl/dcache_ctrl_fsm.sv
// Data-cache miss controller: zero-cycle hit strobes, optional dirty-line
// write-back burst, then a line refill burst over valid/ready memory channels.
module dcache_ctrl_fsm #(
  parameter int unsigned BLOCK_WORDS = 16,
  parameter int unsigned CNT_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start_cache,
  input  logic             i_write_state,
  input  logic             i_hit,
  input  logic             i_dirty,
  output logic             o_stall,
  output logic             o_data_we,
  output logic             o_dirty_set,
  output logic             o_lru_update,
  output logic             o_refill_we,
  output logic             o_tag_we,
  output logic             o_addr_victim,
  output logic [CNT_W-1:0] o_word_cnt,
  output logic             o_mem_arvalid,
  input  logic             i_mem_arready,
  input  logic             i_mem_rvalid,
  output logic             o_mem_rready,
  output logic             o_mem_awvalid,
  input  logic             i_mem_awready,
  output logic             o_mem_wvalid,
  input  logic             i_mem_wready,
  output logic             o_mem_wlast,
  input  logic             i_mem_bvalid,
  output logic             o_mem_bready
);

  typedef enum logic [2:0] {
    IDLE,
    WB_ADDR,
    WB_DATA,
    WB_RESP,
    RF_ADDR,
    RF_DATA
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_beat;
  logic             idle;

  logic awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q, victim_q;

  assign last_beat = (cnt_q == LAST_BEAT);
  assign idle      = (state_q == IDLE);

  // Next-state and beat-counter logic; counter wraps naturally (power-of-two line)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_start_cache && !i_hit) begin
          state_d = i_dirty ? WB_ADDR : RF_ADDR;
          cnt_d   = '0;
        end
      end
      WB_ADDR: begin
        if (i_mem_awready) state_d = WB_DATA;
      end
      WB_DATA: begin
        if (i_mem_wready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = WB_RESP;
        end
      end
      WB_RESP: begin
        if (i_mem_bvalid) state_d = RF_ADDR;
      end
      RF_ADDR: begin
        cnt_d = '0;
        if (i_mem_arready) state_d = RF_DATA;
      end
      RF_DATA: begin
        if (i_mem_rvalid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and memory-side outputs; outputs are registered from the
  // next state so they remain pure functions of the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      victim_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      awvalid_q <= (state_d == WB_ADDR);
      wvalid_q  <= (state_d == WB_DATA);
      wlast_q   <= (state_d == WB_DATA) && (cnt_d == LAST_BEAT);
      bready_q  <= (state_d == WB_RESP);
      arvalid_q <= (state_d == RF_ADDR);
      rready_q  <= (state_d == RF_DATA);
      victim_q  <= (state_d == WB_ADDR) || (state_d == WB_DATA);
    end
  end

  // Core-side strobes: combinational so a hit completes in the request cycle
  always_comb begin
    o_stall      = !idle || (i_start_cache && !i_hit);
    o_lru_update = idle && i_start_cache && i_hit;
    o_data_we    = o_lru_update && i_write_state;
    o_dirty_set  = o_lru_update && i_write_state;
    o_refill_we  = rready_q && i_mem_rvalid;
    o_tag_we     = rready_q && i_mem_rvalid && last_beat;
  end

  assign o_word_cnt    = cnt_q;
  assign o_mem_awvalid = awvalid_q;
  assign o_mem_wvalid  = wvalid_q;
  assign o_mem_wlast   = wlast_q;
  assign o_mem_bready  = bready_q;
  assign o_mem_arvalid = arvalid_q;
  assign o_mem_rready  = rready_q;
  assign o_addr_victim = victim_q;

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Self-checking bench for dcache_ctrl_fsm: directed misses with backpressure,
// reset mid-burst, then randomized traffic against a transaction-level model.
module tb_dcache_ctrl_fsm;

  localparam int BW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          i_start_cache, i_write_state, i_hit, i_dirty;
  logic          o_stall, o_data_we, o_dirty_set, o_lru_update;
  logic          o_refill_we, o_tag_we, o_addr_victim;
  logic [CW-1:0] o_word_cnt;
  logic          o_mem_arvalid, i_mem_arready, i_mem_rvalid, o_mem_rready;
  logic          o_mem_awvalid, i_mem_awready, o_mem_wvalid, i_mem_wready;
  logic          o_mem_wlast, i_mem_bvalid, o_mem_bready;

  int checks = 0;
  int errors = 0;

  // Transaction-level model of an outstanding miss
  bit m_busy, m_wb, m_aw, m_b, m_ar;
  int m_wbn, m_rfn;

  dcache_ctrl_fsm #(.BLOCK_WORDS(BW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_start_cache(i_start_cache), .i_write_state(i_write_state),
    .i_hit(i_hit), .i_dirty(i_dirty),
    .o_stall(o_stall), .o_data_we(o_data_we), .o_dirty_set(o_dirty_set),
    .o_lru_update(o_lru_update), .o_refill_we(o_refill_we), .o_tag_we(o_tag_we),
    .o_addr_victim(o_addr_victim), .o_word_cnt(o_word_cnt),
    .o_mem_arvalid(o_mem_arvalid), .i_mem_arready(i_mem_arready),
    .i_mem_rvalid(i_mem_rvalid), .o_mem_rready(o_mem_rready),
    .o_mem_awvalid(o_mem_awvalid), .i_mem_awready(i_mem_awready),
    .o_mem_wvalid(o_mem_wvalid), .i_mem_wready(i_mem_wready),
    .o_mem_wlast(o_mem_wlast), .i_mem_bvalid(i_mem_bvalid),
    .o_mem_bready(o_mem_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model
  task automatic step(input logic rs, st, wr, ht, dt, aw, w, b, ar, r);
    logic e_aw, e_w, e_wl, e_b, e_ar, e_r, e_lru, e_rwe;
    int   e_cnt;
    @(negedge clk);
    rst = rs; i_start_cache = st; i_write_state = wr; i_hit = ht; i_dirty = dt;
    i_mem_awready = aw; i_mem_wready = w; i_mem_bvalid = b;
    i_mem_arready = ar; i_mem_rvalid = r;
    #1;
    e_aw  = m_busy && m_wb && !m_aw;
    e_w   = m_busy && m_wb && m_aw && (m_wbn < BW);
    e_wl  = e_w && (m_wbn == BW - 1);
    e_b   = m_busy && m_wb && (m_wbn == BW) && !m_b;
    e_ar  = m_busy && (!m_wb || m_b) && !m_ar;
    e_r   = m_busy && m_ar;
    e_lru = !m_busy && st && ht;
    e_rwe = e_r && r;
    e_cnt = e_w ? m_wbn : (e_r ? m_rfn : 0);
    chk("stall",   o_stall,       m_busy || (st && !ht));
    chk("lru",     o_lru_update,  e_lru);
    chk("data_we", o_data_we,     e_lru && wr);
    chk("dirty",   o_dirty_set,   e_lru && wr);
    chk("awvalid", o_mem_awvalid, e_aw);
    chk("wvalid",  o_mem_wvalid,  e_w);
    chk("wlast",   o_mem_wlast,   e_wl);
    chk("bready",  o_mem_bready,  e_b);
    chk("arvalid", o_mem_arvalid, e_ar);
    chk("rready",  o_mem_rready,  e_r);
    chk("victim",  o_addr_victim, e_aw || e_w);
    chk("refill",  o_refill_we,   e_rwe);
    chk("tag_we",  o_tag_we,      e_rwe && (m_rfn == BW - 1));
    chk("cnt",     32'(o_word_cnt), e_cnt);
    if (rs) begin
      m_busy = 0; m_wb = 0; m_aw = 0; m_b = 0; m_ar = 0; m_wbn = 0; m_rfn = 0;
    end else if (!m_busy) begin
      if (st && !ht) begin
        m_busy = 1; m_wb = dt; m_aw = 0; m_b = 0; m_ar = 0; m_wbn = 0; m_rfn = 0;
      end
    end else if (e_aw) begin
      if (aw) m_aw = 1;
    end else if (e_w) begin
      if (w) m_wbn++;
    end else if (e_b) begin
      if (b) m_b = 1;
    end else if (e_ar) begin
      if (ar) m_ar = 1;
    end else if (r) begin
      m_rfn++;
      if (m_rfn == BW) m_busy = 0;
    end
  endtask

  // Full miss: mode 0 = eager memory (arready after 2 cycles), 1 = patterned
  // backpressure, 2 = random readiness with start dropped mid-miss
  task automatic run_miss(input logic wr, dt, input int mode);
    logic aw, w, b, ar, r, st;
    int   k;
    step(0, 1, wr, 0, dt, 0, 0, 0, 0, 0);
    k = 0;
    while (m_busy && k < 400) begin
      st = 1;
      case (mode)
        0: begin aw = 1; w = 1; b = 1; ar = (k >= 2); r = 1; end
        1: begin
          aw = (k % 2 == 1); w = (k % 4 == 0) || (k % 4 == 3);
          b = (k % 3 == 2); ar = 1; r = (k % 4 == 3);
        end
        default: begin
          aw = $urandom % 2; w = $urandom % 2; b = $urandom % 2;
          ar = $urandom % 2; r = $urandom % 2; st = $urandom % 2;
        end
      endcase
      step(0, st, wr, 0, $urandom % 2, aw, w, b, ar, r);
      k++;
    end
    checks++;
    assert (k < 400) else begin
      errors++;
      $error("FAIL miss_timeout got %0d exp <400", k);
    end
    // line now resident: the held request completes through the hit path
    step(0, 1, wr, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    rst = 1; i_start_cache = 0; i_write_state = 0; i_hit = 0; i_dirty = 0;
    i_mem_awready = 0; i_mem_wready = 0; i_mem_bvalid = 0;
    i_mem_arready = 0; i_mem_rvalid = 0;
    m_busy = 0; m_wb = 0; m_aw = 0; m_b = 0; m_ar = 0; m_wbn = 0; m_rfn = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);   // load hit
    step(0, 1, 1, 1, 1, 0, 0, 0, 0, 0);   // store hit
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    run_miss(0, 0, 0);                    // clean load miss
    run_miss(1, 1, 0);                    // dirty store miss
    run_miss(1, 1, 1);                    // backpressure
    run_miss(0, 0, 1);

    // reset in the middle of a refill burst
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    k = 0;
    while (!(m_ar && m_rfn == 7) && k < 100) begin
      step(0, 1, 0, 0, 0, 1, 1, 1, 1, 1);
      k++;
    end
    checks++;
    assert (k < 100) else begin
      errors++;
      $error("FAIL rst_setup_timeout got %0d exp <100", k);
    end
    step(1, 1, 0, 0, 0, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_miss(0, 0, 0);

    for (int i = 0; i < 6; i++) run_miss(1'($urandom % 2), 1'($urandom % 2), 2);

    for (int i = 0; i < 1500; i++)
      step(($urandom % 64) == 0, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2,
           ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
           ($urandom % 4) != 0, ($urandom % 4) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl_fsm.md
Name: dcache_ctrl_fsm

Overview:
- Responder-side controller for the data cache, sitting between the multicycle core's main control FSM and the external memory port.
- Accepts start requests (read or store) from the core and returns a combinational stall while a request cannot complete.
- On a miss it sequences an optional dirty write-back, then a burst line refill over a valid/ready memory interface.
- It also issues the cache-array write strobes.

Parameters:
BLOCK_WORDS, 16, words per cache line; power of two, >=2
CNT_W, $clog2(BLOCK_WORDS), width of the beat counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_start_cache  in  1  core requests a data access this cycle
i_write_state  in  1  1 = store, 0 = load; valid with i_start_cache
i_hit  in  1  tag compare result for current address (valid line, tag match)
i_dirty  in  1  victim line dirty bit
o_stall  out  1  combinational; core must hold request while high
o_data_we  out  1  store-hit word write into cache array
o_dirty_set  out  1  set dirty bit of hit line (with o_data_we)
o_lru_update  out  1  update replacement state on any hit completion
o_refill_we  out  1  write refill word o_word_cnt into line array
o_tag_we  out  1  write new tag, set valid, clear dirty (last refill beat)
o_addr_victim  out  1  memory address uses victim tag (write-back phase)
o_word_cnt  out  CNT_W  current beat index
o_mem_arvalid  out  1  read-burst address valid
i_mem_arready  in  1  read address accepted
i_mem_rvalid  in  1  read data beat valid
o_mem_rready  out  1  ready for read beat
o_mem_awvalid  out  1  write-burst address valid
i_mem_awready  in  1  write address accepted
o_mem_wvalid  out  1  write data beat valid
i_mem_wready  in  1  write beat accepted
o_mem_wlast  out  1  last write beat
i_mem_bvalid  in  1  write response valid
o_mem_bready  out  1  ready for write response

Behaviour:
- States: IDLE, WB_ADDR, WB_DATA, WB_RESP, RF_ADDR, RF_DATA. Reset: state=IDLE, o_word_cnt=0; every output 0 except as derived below.
- IDLE with !i_start_cache: o_stall=0, no strobes.
- IDLE with i_start_cache & i_hit: o_stall=0 in the same cycle (zero-cycle hit) and o_lru_update=1. If i_write_state, also o_data_we=1 and o_dirty_set=1. Remain in IDLE.
- IDLE with i_start_cache & !i_hit: o_stall=1. Next state is WB_ADDR if i_dirty, else RF_ADDR. o_word_cnt cleared.
- o_stall=1 in every non-IDLE state.
- WB_ADDR: o_mem_awvalid=1, o_addr_victim=1. Go to WB_DATA when i_mem_awready.
- WB_DATA: o_mem_wvalid=1, o_addr_victim=1, o_mem_wlast=(o_word_cnt==BLOCK_WORDS-1). On i_mem_wready, o_word_cnt increments (wraps to 0 after last). After the last accepted beat, go to WB_RESP.
- WB_RESP: o_mem_bready=1. Go to RF_ADDR when i_mem_bvalid.
- RF_ADDR: o_mem_arvalid=1. Go to RF_DATA when i_mem_arready. o_word_cnt=0.
- RF_DATA: o_mem_rready=1. Each beat with i_mem_rvalid gives o_refill_we=1 for word o_word_cnt, and the counter increments. On the beat with o_word_cnt==BLOCK_WORDS-1: o_tag_we=1, counter wraps to 0, next state IDLE.
- After refill, IDLE re-evaluates i_hit (now 1). The request completes with hit behaviour one cycle later, so a store miss writes its word via the normal hit path.
- Valid signals stay asserted until the matching ready; payload selects are stable meanwhile. rvalid and wready gaps stall the counter.
- i_start_cache deasserting mid-miss does not abort; the sequence runs to IDLE.
- rst has priority in any state, including mid-burst: state=IDLE, counter=0, all outputs 0 next cycle.
- Memory-side outputs are decoded from state only. o_refill_we, o_tag_we and the IDLE strobes also depend on the current-cycle inputs.

Test Plan:
- Load hit: start=1, write=0, hit=1 in IDLE -> stall=0, lru_update=1, data_we=0 same cycle; state stays IDLE.
- Store hit: start=1, write=1, hit=1 -> data_we=1, dirty_set=1, stall=0 for exactly that cycle.
- Clean load miss, BLOCK_WORDS=16, arready after 2 cycles, rvalid every cycle -> stall high, 16 refill_we pulses with cnt 0..15, tag_we only on cnt 15; hit completes next IDLE cycle.
- Dirty store miss -> awvalid, then 16 wvalid beats with wlast on beat 15, bready until bvalid, then refill. Finally data_we=1, dirty_set=1 once hit=1.
- Backpressure: wready toggles 1,0,0,1 and rvalid has 3-cycle gaps -> counter advances only on accepted beats; wvalid and awvalid never drop before acceptance.
- rst=1 during RF_DATA at cnt=7 -> next cycle state IDLE, cnt=0, all outputs 0. A following clean miss refills from cnt 0.
